// File: rtl/mem_port_arb_if.sv
// mem_port_arb_if
// Bundles the fetch port, the data port and the shared memory port of the
// arbiter, plus the err/busy status outputs.
//   slave  : arbiter view (requests and mem responses in, acks and mem drive out)
//   master : environment view (requesters and memory model)
interface mem_port_arb_if;
    // fetch port
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    // data port
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    // shared memory port
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    // status
    logic        err;
    logic        busy;

    modport slave (
        input  if_req, if_addr,
        output if_ack, if_rdata,
        input  dm_req, dm_we, dm_addr, dm_wdata,
        output dm_ack, dm_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack,
        output err, busy
    );

    modport master (
        output if_req, if_addr,
        input  if_ack, if_rdata,
        output dm_req, dm_we, dm_addr, dm_wdata,
        input  dm_ack, dm_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack,
        input  err, busy
    );
endinterface

// File: rtl/mem_port_arb.sv
// mem_port_arb
// Arbitrates a fetch port and a data port onto one shared memory port, one
// transfer at a time. The data port has priority; after STARVE_MAX
// consecutive data grants with fetch waiting, fetch wins. A transfer not
// acknowledged within TMO_CYC cycles completes with err and rdata=0.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : mem_port_arb_if.slave (fetch, data and memory ports, err, busy)
//
// state | meaning
// IDLE  | no transfer; arbitrate pending requests and latch the winner
// ISSUE | mem_req high with latched command; wait for mem_ack or timeout
// RESP  | one-cycle ack pulse to the winner with rdata (and err)
module mem_port_arb #(
    parameter int STARVE_MAX = 2,
    parameter int TMO_CYC    = 64
) (
    input  logic           clk,
    input  logic           rst,
    mem_port_arb_if.slave  bus
);
    localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam int TW = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
    localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_MAX);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TMO_CYC - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t        state_q,  state_d;
    logic          fetch_q,  fetch_d;
    logic          we_q,     we_d;
    logic [31:0]   addr_q,   addr_d;
    logic [31:0]   wdata_q,  wdata_d;
    logic [31:0]   rdata_q,  rdata_d;
    logic          err_q,    err_d;
    logic [SW-1:0] streak_q, streak_d;
    logic [TW-1:0] tmo_q,    tmo_d;

    logic fetch_win;

    always_comb begin
        state_d   = state_q;
        fetch_d   = fetch_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        streak_d  = streak_q;
        tmo_d     = tmo_q;
        fetch_win = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.if_req || bus.dm_req) begin
                    fetch_win = bus.if_req && (!bus.dm_req || (streak_q == STREAK_MAX));
                    fetch_d   = fetch_win;
                    if (fetch_win) begin
                        we_d     = 1'b0;
                        addr_d   = bus.if_addr;
                        wdata_d  = 32'h0;
                        streak_d = '0;
                    end else begin
                        we_d    = bus.dm_we;
                        addr_d  = bus.dm_addr;
                        wdata_d = bus.dm_wdata;
                        // Streak only grows while fetch is actually waiting.
                        if (!bus.if_req)
                            streak_d = '0;
                        else if (streak_q != STREAK_MAX)
                            streak_d = streak_q + SW'(1);
                    end
                    rdata_d = 32'h0;
                    err_d   = 1'b0;
                    tmo_d   = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // An ack in the timeout cycle still counts as a normal completion.
                if (bus.mem_ack) begin
                    rdata_d = we_q ? 32'h0 : bus.mem_rdata;
                    state_d = RESP;
                end else if (tmo_q == TMO_LAST) begin
                    rdata_d = 32'h0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            fetch_q  <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
            streak_q <= '0;
            tmo_q    <= '0;
        end else begin
            state_q  <= state_d;
            fetch_q  <= fetch_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            streak_q <= streak_d;
            tmo_q    <= tmo_d;
        end
    end

    logic in_issue;
    logic in_resp;
    assign in_issue = (state_q == ISSUE);
    assign in_resp  = (state_q == RESP);

    assign bus.mem_req   = in_issue;
    assign bus.mem_we    = in_issue & we_q;
    assign bus.mem_addr  = in_issue ? addr_q  : 32'h0;
    assign bus.mem_wdata = in_issue ? wdata_q : 32'h0;

    assign bus.if_ack   = in_resp & fetch_q;
    assign bus.dm_ack   = in_resp & ~fetch_q;
    assign bus.if_rdata = (in_resp &  fetch_q) ? rdata_q : 32'h0;
    assign bus.dm_rdata = (in_resp & ~fetch_q) ? rdata_q : 32'h0;
    assign bus.err      = in_resp & err_q;
    assign bus.busy     = (state_q != IDLE);
endmodule
